// File: rtl/spi_cfg_master_pkg.sv
// Shared definitions for the SPI configuration master.
//   state_t : FSM state encoding used by spi_cfg_master
//   max2    : elaboration-time helper for sizing counters
package spi_cfg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_HELD  = 3'd4
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_cfg_master_sck_gen.sv
// Serial clock generator for spi_cfg_master (mode 0, sck idles low).
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-low reset
//   en         in  run the divider; while low sck is forced low and the divider rearmed
//   sck        out serial clock, each phase CLK_DIV clk cycles
//   rise_pulse out high in the cycle whose closing edge drives sck 0->1
//   fall_pulse out high in the cycle whose closing edge drives sck 1->0
module spi_cfg_master_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             sck_q;
  logic             tc;

  // Down-counter rearmed while disabled, so the first rise after enable
  // lands a full half-period later and mosi gets its setup time.
  assign tc         = (div_cnt == '0);
  assign rise_pulse = en && tc && !sck_q;
  assign fall_pulse = en && tc && sck_q;
  assign sck        = sck_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= DIV_LD;
      sck_q   <= 1'b0;
    end else if (!en) begin
      div_cnt <= DIV_LD;
      sck_q   <= 1'b0;
    end else if (tc) begin
      div_cnt <= DIV_LD;
      sck_q   <= ~sck_q;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, one DATA_W frame per start.
// Optionally keeps ss low after a frame so multi-byte transactions run back to back.
//
// state | meaning
// IDLE  | ss high, waiting for start
// SETUP | ss low, sck low, CS_SETUP cycles before the clock runs
// XFER  | sck running, shifting mosi out and miso in
// HOLD  | sck low, CS_HOLD cycles before done
// HELD  | ss kept low between chained frames, waiting for start
//
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   start, hold       frame request and keep-ss-low flag (sampled together)
//   tx_data           frame to send, sampled with start
//   busy, done        frame in progress, one-cycle completion pulse
//   rx_data           last received frame, updated with done
//   ss, sck, mosi     SPI outputs; miso SPI input
module spi_cfg_master
  import spi_cfg_master_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ss,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int PH_W  = $clog2(max2(CS_SETUP, CS_HOLD) + 1);
  localparam logic [PH_W-1:0]  SETUP_LD = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]  HOLD_LD  = PH_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  state_t             state_q, state_d;
  logic [PH_W-1:0]    ph_cnt_q, ph_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               hold_q, hold_d;
  logic               ss_q, ss_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_ok;
  logic               sck_en, rise_pulse, fall_pulse;

  // busy stays high through the done cycle, so a start coinciding with done is ignored.
  assign start_ok = start && !busy_q;
  assign sck_en   = (state_q == ST_XFER);

  spi_cfg_master_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (sck_en),
    .sck        (sck),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    hold_d     = hold_q;
    ss_d       = ss_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start_ok) begin
          state_d  = ST_SETUP;
          ph_cnt_d = SETUP_LD;
          ss_d     = 1'b0;
        end
      end
      ST_SETUP: begin
        if (ph_cnt_q == '0) state_d = ST_XFER;
        else                ph_cnt_d = ph_cnt_q - PH_W'(1);
      end
      ST_XFER: begin
        if (rise_pulse) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        end
        if (fall_pulse) begin
          // Last fall leaves the final bit on mosi through HOLD.
          if (bit_cnt_q == BIT_LAST) begin
            state_d  = ST_HOLD;
            ph_cnt_d = HOLD_LD;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        if (ph_cnt_q == '0) begin
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          if (hold_q) begin
            state_d = ST_HELD;
          end else begin
            ss_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          ph_cnt_d = ph_cnt_q - PH_W'(1);
        end
      end
      ST_HELD: begin
        busy_d = 1'b0;
        if (start_ok) state_d = ST_XFER;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_ok && (state_q == ST_IDLE || state_q == ST_HELD)) begin
      tx_shift_d = tx_data;
      hold_d     = hold;
      bit_cnt_d  = '0;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ph_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      hold_q     <= 1'b0;
      ss_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      hold_q     <= hold_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // mosi is the registered MSB of the transmit shifter, so it only moves on sck falls.
  assign mosi    = tx_shift_q[DATA_W-1];
  assign ss      = ss_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
module tb_spi_cfg_master;

  localparam int DATA_W   = 8;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int LAT_IDLE = CS_SETUP + 2 * DATA_W * CLK_DIV + CS_HOLD + 1;
  localparam int LAT_HELD = LAT_IDLE - CS_SETUP;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              hold;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              ss;
  logic              sck;
  logic              mosi;
  logic              miso;

  always #5 clk = ~clk;

  spi_cfg_master #(
    .DATA_W   (DATA_W),
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hold    (hold),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .ss      (ss),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Slave model: 0 = loopback, 1 = constant one, 2 = shift out pattern word MSB first.
  logic [1:0]        miso_mode;
  logic [DATA_W-1:0] pat_v;
  int                n_rise;
  logic [DATA_W-1:0] mosi_bits;
  logic              pat_bit;

  always_comb begin
    pat_bit = 1'b0;
    if (n_rise < DATA_W) pat_bit = pat_v[DATA_W-1-n_rise];
  end

  assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1) ? 1'b1 : pat_bit;

  always @(posedge sck) begin
    mosi_bits = {mosi_bits[DATA_W-2:0], mosi};
    n_rise    = n_rise + 1;
  end

  typedef struct {
    logic [DATA_W-1:0] rx;
    logic [DATA_W-1:0] tx;
    int                start_cyc;
    int                lat;
    logic              ss_end;
  } exp_t;

  exp_t sb_q[$];
  bit   held_m = 1'b0;

  int   cyc = 0;
  int   done_cnt = 0;
  int   proto_err = 0;
  int   hi_run = 0;
  logic sck_p, ss_p, mosi_p, busy_p;
  exp_t mon_e;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rx_data", int'(rx_data), int'(mon_e.rx));
        chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
        chk("rise_count", n_rise, DATA_W);
        chk("mosi_seq", int'(mosi_bits), int'(mon_e.tx));
        chk("ss_at_done", int'(ss), int'(mon_e.ss_end));
      end
    end
    if (sck_p === 1'b1 && sck === 1'b1 && mosi !== mosi_p) proto_err++;
    if (ss === 1'b1 && sck === 1'b1) proto_err++;
    if (ss_p === 1'b0 && ss === 1'b1 && sck_p === 1'b1 && rst === 1'b1) proto_err++;
    if (busy_p === 1'b1 && busy === 1'b1 && done !== 1'b1 && ss !== ss_p && rst === 1'b1) proto_err++;
    if (sck === 1'b1) begin
      hi_run++;
    end else begin
      if (sck_p === 1'b1 && rst === 1'b1 && hi_run != CLK_DIV) proto_err++;
      hi_run = 0;
    end
    sck_p  = sck;
    ss_p   = ss;
    mosi_p = mosi;
    busy_p = busy;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [DATA_W-1:0] tx, input logic h, input logic [1:0] mode,
                       input logic [DATA_W-1:0] pat, input bit expect_done);
    exp_t e;
    wait_idle();
    miso_mode = mode;
    pat_v     = pat;
    n_rise    = 0;
    mosi_bits = '0;
    tx_data   = tx;
    hold      = h;
    start     = 1'b1;
    if (expect_done) begin
      e.rx        = (mode == 2'd0) ? tx : (mode == 2'd1) ? {DATA_W{1'b1}} : pat;
      e.tx        = tx;
      e.start_cyc = cyc;
      e.lat       = held_m ? LAT_HELD : LAT_IDLE;
      e.ss_end    = !h;
      sb_q.push_back(e);
      held_m = h;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", sb_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int n;
    rst = 1'b0; start = 1'b0; hold = 1'b0; tx_data = '0;
    miso_mode = 2'd0; pat_v = '0; n_rise = 0; mosi_bits = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss", int'(ss), 1);
    chk("rst_sck", int'(sck), 0);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    rst = 1'b1;

    issue(8'hB6, 1'b0, 2'd0, '0, 1'b1);
    drain();

    issue(8'h00, 1'b0, 2'd1, '0, 1'b1);
    drain();

    issue(8'hA5, 1'b1, 2'd0, '0, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    chk("ss_held_between", int'(ss), 0);
    chk("busy_in_held", int'(busy), 0);
    issue(8'h3C, 1'b0, 2'd0, '0, 1'b1);
    drain();
    @(negedge clk);
    chk("ss_released", int'(ss), 1);

    dc = done_cnt;
    issue(8'h69, 1'b0, 2'd0, '0, 1'b1);
    repeat (40) begin
      start   = 1'b1;
      tx_data = DATA_W'($urandom);
      hold    = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("single_done", done_cnt - dc, 1);

    for (int i = 0; i < 10; i++) begin
      issue(DATA_W'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), DATA_W'($urandom), 1'b1);
      drain();
    end
    if (held_m) begin
      issue(DATA_W'($urandom), 1'b0, 2'd2, DATA_W'($urandom), 1'b1);
      drain();
    end

    dc = done_cnt;
    issue(8'hC3, 1'b0, 2'd0, '0, 1'b0);
    n = 0;
    while (n_rise < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_rise4", n_rise, 4);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ss", int'(ss), 1);
    chk("abort_sck", int'(sck), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rx_data", int'(rx_data), 0);
    @(negedge clk);
    rst    = 1'b1;
    held_m = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);

    issue(8'h5A, 1'b0, 2'd2, 8'hE1, 1'b1);
    drain();
    repeat (5) @(negedge clk);

    chk("protocol_violations", proto_err, 0);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
